// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_IFETCH = 0;
  localparam int unsigned REQ_DATA   = 1;
  localparam int unsigned REQ_VEC    = 2;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    winner_o,
  output logic             valid_o
);

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_i) + i) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        winner_o = PW'(idx);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single MMU memory port, one transaction in flight.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*32-1:0]      addr_i,
  input  logic [N_REQ-1:0]         we_i,
  input  logic [N_REQ*MEM_W/8-1:0] be_i,
  input  logic [N_REQ*MEM_W-1:0]   wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         rvalid_o,
  output logic [N_REQ-1:0]         err_o,
  output logic [MEM_W-1:0]         rdata_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  output logic                     mem_we_o,
  output logic [MEM_W/8-1:0]       mem_be_o,
  output logic [MEM_W-1:0]         mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_err_i,
  input  logic [MEM_W-1:0]         mem_rdata_i,
  output logic                     busy_o,
  output logic                     spurious_o
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = MEM_W / 8;

  arb_state_e         state_q;
  logic [PW-1:0]      rr_ptr_q, winner_q, pick_idx, rr_next;
  logic               pick_valid;
  logic [31:0]        addr_q, sel_addr;
  logic               we_q, sel_we;
  logic [BW-1:0]      be_q, sel_be;
  logic [MEM_W-1:0]   wdata_q, sel_wdata;
  logic               spurious_q;
  logic               busy, resp_c, timeout_c;
  logic [N_REQ-1:0]   win_oh, pick_oh;

  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      if (PW'(r) == pick_idx) begin
        sel_addr  = addr_i[r*32 +: 32];
        sel_we    = we_i[r];
        sel_be    = be_i[r*BW +: BW];
        sel_wdata = wdata_i[r*MEM_W +: MEM_W];
      end
    end
  end

  assign busy    = (state_q != ARB_IDLE);
  assign resp_c  = busy && (mem_rvalid_i || mem_err_i);
  assign win_oh  = N_REQ'(1) << winner_q;
  assign pick_oh = N_REQ'(1) << pick_idx;
  assign rr_next = (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign timeout_c = busy && (cnt_q == 16'(TIMEOUT_CYCLES));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      winner_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      spurious_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      if (!busy && (mem_rvalid_i || mem_err_i)) spurious_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      if (busy) cnt_q <= cnt_q + 16'd1;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            winner_q <= pick_idx;
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            be_q     <= sel_be;
            wdata_q  <= sel_wdata;
            state_q  <= ARB_ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ARB_ISSUE, ARB_WAIT: begin
          // A response (or watchdog expiry) ends the transaction even while still in ISSUE.
          if (resp_c || timeout_c) begin
            rr_ptr_q <= rr_next;
            state_q  <= ARB_IDLE;
          end else begin
            state_q  <= ARB_WAIT;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_o       = (!busy && pick_valid) ? pick_oh : '0;
  assign rvalid_o    = (busy && mem_rvalid_i && !mem_err_i) ? win_oh : '0;
  assign err_o       = (busy && (mem_err_i || timeout_c)) ? win_oh : '0;
  assign rdata_o     = busy ? mem_rdata_i : '0;
  assign mem_req_o   = (state_q == ARB_ISSUE);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy;
  assign spurious_o  = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change on negedge, checks #1 later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, gnt, rvalid, err;
  logic [95:0] addr, wdata;
  logic [11:0] be;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_rvalid, mem_err, busy, spurious;
  logic [3:0]  mem_be;

  int ncmp = 0;
  int nerr = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(3), .MEM_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .addr_i       (addr),
    .we_i         (we),
    .be_i         (be),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .err_o        (err),
    .rdata_o      (rdata),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_rvalid_i (mem_rvalid),
    .mem_err_i    (mem_err),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .spurious_o   (spurious)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_spurious", 64'(spurious), 0);
    chk("rst_rdata", 64'(rdata), 0);
    @(negedge clk); rst = 1'b0;

    // Single request from requester 1
    @(negedge clk); req = 3'b010; addr[32 +: 32] = 32'h1004; we = 3'b000; #1;
    chk("single_gnt", 64'(gnt), 64'b010);
    chk("single_req_T", 64'(mem_req), 0);
    @(negedge clk); req = '0; #1;
    chk("single_mem_req", 64'(mem_req), 1);
    chk("single_mem_addr", 64'(mem_addr), 64'h1004);
    chk("single_mem_we", 64'(mem_we), 0);
    chk("single_gnt_issue", 64'(gnt), 0);
    @(negedge clk); #1;
    chk("single_wait_req", 64'(mem_req), 0);
    chk("single_wait_addr", 64'(mem_addr), 64'h1004);
    chk("single_busy", 64'(busy), 1);
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("single_rvalid", 64'(rvalid), 64'b010);
    chk("single_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("single_err", 64'(err), 0);
    @(negedge clk); mem_rvalid = 1'b0; #1;
    chk("single_idle", 64'(busy), 0);
    chk("single_rdata_idle", 64'(rdata), 0);

    // Write from requester 2 that errors; err wins over simultaneous rvalid
    @(negedge clk); req = 3'b100; we = 3'b100; addr[64 +: 32] = 32'h0050;
    be[8 +: 4] = 4'hF; wdata[64 +: 32] = 32'hCAFEF00D; #1;
    chk("err_gnt", 64'(gnt), 64'b100);
    @(negedge clk); req = '0; we = '0; #1;
    chk("err_mem_req", 64'(mem_req), 1);
    chk("err_mem_addr", 64'(mem_addr), 64'h50);
    chk("err_mem_we", 64'(mem_we), 1);
    chk("err_mem_be", 64'(mem_be), 64'hF);
    chk("err_mem_wdata", 64'(mem_wdata), 64'hCAFEF00D);
    @(negedge clk); mem_err = 1'b1; mem_rvalid = 1'b1; #1;
    chk("err_err", 64'(err), 64'b100);
    chk("err_rvalid", 64'(rvalid), 0);
    @(negedge clk); mem_err = 1'b0; mem_rvalid = 1'b0;

    // Contention: all request, each response arrives in the ISSUE cycle
    addr[0 +: 32] = 32'hA000; addr[32 +: 32] = 32'hA004; addr[64 +: 32] = 32'hA008;
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("rr_gnt", 64'(gnt), 64'(3'b001 << (t % 3)));
      if (mem_req) pulses++;
      @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'(t); #1;
      if (mem_req) pulses++;
      chk("rr_mem_req", 64'(mem_req), 1);
      chk("rr_mem_addr", 64'(mem_addr), 64'(32'hA000 + 32'((t % 3) * 4)));
      chk("rr_rvalid", 64'(rvalid), 64'(3'b001 << (t % 3)));
      chk("rr_gnt_resp", 64'(gnt), 0);
      @(negedge clk); mem_rvalid = 1'b0;
      if (t == 3) req = '0;
    end
    chk("rr_pulses", 64'(pulses), 4);

    // Reset while waiting, then a late response
    @(negedge clk); req = 3'b001; #1;
    chk("rstw_gnt", 64'(gnt), 64'b001);
    @(negedge clk); req = '0;
    @(negedge clk); #1;
    chk("rstw_busy", 64'(busy), 1);
    rst = 1'b1; #1;
    chk("rstw_busy_rst", 64'(busy), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    chk("rstw_rvalid", 64'(rvalid), 0);
    chk("rstw_rdata", 64'(rdata), 0);
    chk("rstw_spur_pre", 64'(spurious), 0);
    @(negedge clk); mem_rvalid = 1'b0; #1;
    chk("rstw_spurious", 64'(spurious), 1);
    chk("rstw_idle", 64'(busy), 0);

`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk); req = 3'b010; #1;
    chk("tmo_gnt", 64'(gnt), 64'b010);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); req = '0; #1;
      chk("tmo_err", 64'(err), (k == 9) ? 64'b010 : 64'd0);
    end
    @(negedge clk); #1;
    chk("tmo_busy", 64'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the MMU (req/addr/we/be/wdata in; rvalid/err/rdata out) between N_REQ requesters: Ibex instruction fetch, Ibex data, and Vicuna vector LSU.
- Round-robin arbitration with exactly one outstanding transaction at a time.
- Holds the winning request stable and routes the MMU response back to its originator.
- Sits between the cores and the mmu instance.

Parameters:
- N_REQ, 3, number of requesters; index 0 = ifetch, 1 = data, 2 = vector.
- MEM_W, 32, data bus width in bits; must match the MMU.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  N_REQ  per-requester request
- addr_i  in  N_REQ*32  per-requester address; slice r = bits [r*32 +: 32]
- we_i  in  N_REQ  per-requester write enable
- be_i  in  N_REQ*MEM_W/8  per-requester byte enables
- wdata_i  in  N_REQ*MEM_W  per-requester write data
- gnt_o  out  N_REQ  one-hot grant
- rvalid_o  out  N_REQ  one-hot response valid
- err_o  out  N_REQ  one-hot response error
- rdata_o  out  MEM_W  response data, shared by all requesters
- mem_req_o  out  1  to MMU vproc_mem_req_o
- mem_addr_o  out  32
- mem_we_o  out  1
- mem_be_o  out  MEM_W/8
- mem_wdata_o  out  MEM_W
- mem_rvalid_i  in  1  from MMU
- mem_err_i  in  1  from MMU
- mem_rdata_i  in  MEM_W  from MMU
- busy_o  out  1  high whenever state != IDLE
- spurious_o  out  1  sticky flag: a response arrived while IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rr_ptr=0, winner=0, latched request fields=0, spurious_o=0.
  - All outputs 0.
  - Reset mid-transaction abandons it: no rvalid/err is issued, and a late MMU response after reset sets spurious_o.
- State machine (3 states):
  - IDLE: if any req_i is high, select the winner = first requester at or after rr_ptr (modulo N_REQ) with req_i high.
    - gnt_o[winner]=1 combinationally in that same cycle.
    - Latch addr/we/be/wdata of the winner and the winner index.
    - Next state ISSUE.
  - ISSUE: mem_req_o=1 for exactly one cycle with the latched fields. Next state WAIT.
  - WAIT: mem_req_o=0. mem_* fields stay at the latched values until the response.
- Response handling:
  - A response is accepted in ISSUE or WAIT: mem_rvalid_i or mem_err_i high.
  - rvalid_o[winner]=mem_rvalid_i and err_o[winner]=mem_err_i, combinationally in the same cycle.
  - rdata_o=mem_rdata_i whenever state != IDLE, else 0.
  - On response: rr_ptr = (winner+1) mod N_REQ; next state IDLE.
  - If both mem_rvalid_i and mem_err_i are high, err wins and rvalid_o is suppressed.
  - A response accepted in ISSUE still emits mem_req_o that cycle, then returns to IDLE.
- Latency:
  - gnt in request cycle T; mem_req_o at T+1; response earliest T+1.
  - New grant earliest in the cycle after the response (no back-to-back grant in the response cycle).
- Requesters hold req_i until gnt_o; after gnt they may drop or change inputs.
- Simultaneous requests: rr_ptr priority. A requester that just finished has lowest priority next round, so there is no starvation.
- Response arriving in IDLE: ignored for routing; sets spurious_o (cleared only by rst).
- rr_ptr width = $clog2(N_REQ), minimum 1. Wrap from N_REQ-1 to 0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT_CYCLES without a response: err_o[winner]=1 for one cycle, rr_ptr advances, state goes to IDLE.
  - A later MMU response for that transaction sets spurious_o.
- Undefined: no counter; WAIT is held indefinitely until a response arrives.

Decomposition:
- Package mem_arb_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - Constants for requester indices (REQ_IFETCH=0, REQ_DATA=1, REQ_VEC=2).
  - Default TIMEOUT_CYCLES.
- Sub-module rr_picker (combinational):
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index and a valid bit.
  - Reusable by later arbiters.

Test Plan:
- Single request: req_i=3'b010, addr 0x1004, we=0 -> gnt_o=3'b010 at T, mem_req_o=1 with addr 0x1004 at T+1; MMU returns rdata 0xDEADBEEF at T+3 -> rvalid_o=3'b010 and rdata_o=0xDEADBEEF at T+3.
- Contention: req_i=3'b111 held, rr_ptr=0 -> grant order 0,1,2,0 across four transactions, with exactly one mem_req_o pulse per grant.
- Error path: requester 2 writes addr 0x0050 and MMU asserts mem_err_i -> err_o=3'b100, rvalid_o=0, rr_ptr becomes 0.
- Reset mid-WAIT: assert rst in WAIT, then MMU asserts rvalid after rst is released -> no rvalid_o, spurious_o=1, state IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): MMU never responds -> err_o[winner]=1 exactly 8 cycles after entering ISSUE, busy_o=0 in the next cycle.
